warp_fetcher: RTL
=================

WARP_FETCHER -- requirements
Module: warp_fetcher

Interface
REQ-001 SHALL have parameter MAX_WARPS_PER_CORE, default 4, meaning the number of per-warp instruction buffer entries.
REQ-002 SHALL have parameter PROGRAM_MEM_ADDR_BITS, default 8, meaning the program memory address width.
REQ-003 SHALL have parameter PROGRAM_MEM_DATA_BITS, default 16, meaning the instruction width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; no other clock or reset exists.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 fetch_req  input  1  scheduler requests an instruction; level, sampled only in IDLE.
REQ-008 fetch_warp_id  input  8  warp being fetched.
REQ-009 fetch_pc  input  PROGRAM_MEM_ADDR_BITS  PC of that warp.
REQ-010 consume  input  1  scheduler has taken the instruction.
REQ-011 flush  input  1  invalidate all buffer entries (new kernel).
REQ-012 instruction_ready  output  1  instruction output valid.
REQ-013 instruction  output  PROGRAM_MEM_DATA_BITS  fetched instruction.
REQ-014 mem_read_valid  output  1  program memory read request.
REQ-015 mem_read_address  output  PROGRAM_MEM_ADDR_BITS  read address.
REQ-016 mem_read_ready  input  1  memory returns data this cycle.
REQ-017 mem_read_data  input  PROGRAM_MEM_DATA_BITS  returned instruction.

Function
REQ-018 SHALL implement FSM states IDLE, LOOKUP, REQUEST, READY.
REQ-019 IDLE: on fetch_req=1, latch fetch_warp_id and fetch_pc, then go to LOOKUP.
REQ-020 LOOKUP, hit (warp id < MAX_WARPS_PER_CORE, entry valid, tag == latched pc): load instruction from the entry, then go to READY; instruction_ready rises 2 cycles after fetch_req is sampled.
REQ-021 LOOKUP, miss: go to REQUEST.
REQ-022 REQUEST: drive mem_read_valid=1 and mem_read_address=latched pc, held stable until mem_read_ready=1.
REQ-023 On mem_read_ready=1 in REQUEST: capture mem_read_data into instruction, write the entry (valid, tag, data) for an in-range warp, drop mem_read_valid next cycle, then go to READY.
REQ-024 READY: instruction_ready=1 and instruction stable until consume=1; then go to IDLE with instruction_ready=0 next cycle.
REQ-025 consume outside READY and mem_read_ready outside REQUEST SHALL be ignored.
REQ-026 Warp id >= MAX_WARPS_PER_CORE: always a miss, never cached, data still delivered.
REQ-027 flush=1: clear all entry valid bits the same edge, in any state, without changing the FSM state.
REQ-028 flush coinciding with a memory return: deliver the data but do not cache it.
REQ-029 One outstanding memory read at most; no new request accepted before READY→IDLE.

Reset
REQ-030 Reset SHALL force IDLE, instruction_ready=0, instruction=0, mem_read_valid=0, mem_read_address=0, and all entry valid bits=0, asynchronously.
REQ-031 Reset mid-REQUEST SHALL abandon the read; a later mem_read_ready SHALL be ignored.

Structure
REQ-032 FSM state encoding and width constants SHALL be in the shared package used by core modules.
REQ-033 The per-warp buffer SHALL be one sub-module, warp_ibuf (valid/tag/data array, lookup port, write port, flush).

Verification
REQ-034 Cold miss: req warp 0, pc 0x05; memory returns 0x1234 after 3 cycles -> mem_read_address=0x05 held 3 cycles; instruction=0x1234 and instruction_ready=1 until consume.
REQ-035 Hit: repeat warp 0, pc 0x05 -> no mem_read_valid; instruction_ready 2 cycles after req; instruction=0x1234.
REQ-036 Tag mismatch: warp 0, pc 0x06 -> memory read issued; entry replaced; a following pc 0x05 request misses.
REQ-037 Flush during REQUEST for warp 1, pc 0x10, data 0xBEEF -> 0xBEEF delivered; an immediate refetch of warp 1, pc 0x10 misses.
REQ-038 Reset asserted mid-REQUEST, then a stray mem_read_ready -> outputs are 0 immediately; FSM stays IDLE; the next fetch misses.
REQ-039 Warp id 7 (MAX_WARPS_PER_CORE=4) -> fetched correctly; a repeat fetch misses again.

Source files
------------

// File: rtl/warp_fetcher_pkg.sv
// Shared definitions for the warp instruction fetch path: FSM encoding and
// width constants used by the fetcher and its per-warp instruction buffer.
package warp_fetcher_pkg;

  localparam int unsigned WARP_ID_BITS = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StRequest,
    StReady
  } fetch_state_e;

  // Index width for an n-entry array; never zero so slices stay legal.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/warp_ibuf.sv
// Per-warp single-entry instruction buffer: valid/tag/data per warp, a
// combinational lookup port, one write port and a global flush.
module warp_ibuf
  import warp_fetcher_pkg::*;
#(
  parameter int unsigned ENTRIES   = 4,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [WARP_ID_BITS-1:0] lookup_id,
  input  logic [ADDR_BITS-1:0]    lookup_tag,
  output logic                    lookup_hit,
  output logic [DATA_BITS-1:0]    lookup_data,
  input  logic                    write_en,
  input  logic [WARP_ID_BITS-1:0] write_id,
  input  logic [ADDR_BITS-1:0]    write_tag,
  input  logic [DATA_BITS-1:0]    write_data
);

  localparam int unsigned IdxBits = idx_bits(ENTRIES);

  logic [ENTRIES-1:0]   valid_q;
  logic [ADDR_BITS-1:0] tag_q  [ENTRIES];
  logic [DATA_BITS-1:0] data_q [ENTRIES];

  logic               lookup_in_range, write_in_range;
  logic [IdxBits-1:0] lookup_idx, write_idx;

  assign lookup_in_range = 32'(lookup_id) < ENTRIES;
  assign write_in_range  = 32'(write_id) < ENTRIES;
  assign lookup_idx      = lookup_id[IdxBits-1:0];
  assign write_idx       = write_id[IdxBits-1:0];

  assign lookup_hit  = lookup_in_range && valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
  assign lookup_data = data_q[lookup_idx];

  // Flush has priority so a fill racing a flush is never left valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (write_en && write_in_range) begin
      valid_q[write_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (write_en && write_in_range) begin
      tag_q[write_idx]  <= write_tag;
      data_q[write_idx] <= write_data;
    end
  end

endmodule

// File: rtl/warp_fetcher.sv
// Warp instruction fetcher: looks up the per-warp buffer, falls back to a
// single outstanding program-memory read on a miss, and holds the result.
module warp_fetcher
  import warp_fetcher_pkg::*;
#(
  parameter int unsigned MAX_WARPS_PER_CORE    = 4,
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
  parameter int unsigned PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             fetch_req,
  input  logic [WARP_ID_BITS-1:0]          fetch_warp_id,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] fetch_pc,
  input  logic                             consume,
  input  logic                             flush,
  output logic                             instruction_ready,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data
);

  fetch_state_e state_q, state_d;

  logic [WARP_ID_BITS-1:0]          warp_q;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] pc_q;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;
  logic                             hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] hit_data;
  logic                             fill_en;

  warp_ibuf #(
    .ENTRIES  (MAX_WARPS_PER_CORE),
    .ADDR_BITS(PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS(PROGRAM_MEM_DATA_BITS)
  ) u_ibuf (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .lookup_id  (warp_q),
    .lookup_tag (pc_q),
    .lookup_hit (hit),
    .lookup_data(hit_data),
    .write_en   (fill_en),
    .write_id   (warp_q),
    .write_tag  (pc_q),
    .write_data (mem_read_data)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    fill_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fetch_req) state_d = StLookup;
      end
      StLookup: begin
        if (hit) begin
          instr_d = hit_data;
          state_d = StReady;
        end else begin
          state_d = StRequest;
        end
      end
      StRequest: begin
        if (mem_read_ready) begin
          instr_d = mem_read_data;
          fill_en = !flush;
          state_d = StReady;
        end
      end
      StReady: begin
        if (consume) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      instr_q <= '0;
      warp_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      if (state_q == StIdle && fetch_req) begin
        warp_q <= fetch_warp_id;
        pc_q   <= fetch_pc;
      end
    end
  end

  assign instruction_ready = (state_q == StReady);
  assign instruction       = instr_q;
  assign mem_read_valid    = (state_q == StRequest);
  assign mem_read_address  = pc_q;

endmodule
